// File: rtl/game_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// game_ctrl_fsm
//
// Game-flow controller for the Pacman datapath. It conditions the five board
// push-buttons (2-flop synchronizer plus counter debouncer), derives a one-cycle
// frame tick from the falling edge of vsync, and sequences the game through
// IDLE -> READY -> PLAY <-> PAUSE, PLAY -> DYING -> READY/OVER -> IDLE.
// While playing it latches the player's direction and issues a move enable
// every MOVE_DIV frames; each READY entry emits a level reset pulse.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles before a button change is accepted
//   MOVE_DIV        : frame ticks per move_en pulse in PLAY
//   READY_FRAMES    : frame ticks spent in READY
//   DEATH_FRAMES    : frame ticks spent in DYING
//   LIVES_INIT      : lives loaded at game start
//
// Ports
//   clk         in   system clock (single domain)
//   rst         in   asynchronous active-high reset
//   btn_u/d/l/r in   raw direction push-buttons, active-high
//   btn_c       in   raw centre push-button, active-high
//   vsync       in   VGA vertical sync, active-low pulse on clk
//   pacman_dead in   collision flag from the datapath (level)
//   game_state  out  IDLE=0 READY=1 PLAY=2 PAUSE=3 DYING=4 OVER=5
//   dir         out  latched direction: 00 up, 01 down, 10 left, 11 right
//   move_en     out  one-cycle sprite step pulse
//   level_rst   out  one-cycle sprite reposition pulse
//   freeze      out  high whenever game_state is not PLAY
//   lives       out  remaining lives
// -----------------------------------------------------------------------------
module game_ctrl_fsm #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter logic [7:0]  MOVE_DIV        = 8'd4,
    parameter logic [7:0]  READY_FRAMES    = 8'd120,
    parameter logic [7:0]  DEATH_FRAMES    = 8'd90,
    parameter logic [1:0]  LIVES_INIT      = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_c,
    input  logic       vsync,
    input  logic       pacman_dead,
    output logic [2:0] game_state,
    output logic [1:0] dir,
    output logic       move_en,
    output logic       level_rst,
    output logic       freeze,
    output logic [1:0] lives
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_DYING = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    logic [4:0] btn_raw;
    logic [4:0] btn_p0;
    logic [4:0] btn_p1;
    logic [4:0] btn_db;
    logic       c_prev;
    logic       c_press;

    logic       vs_p0;
    logic       vs_p1;
    logic       vs_p2;
    logic       frame_tick;

    state_t     state_q;
    logic [7:0] fcnt;

    assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

    // ---- stage p0/p1: two-flop synchronizers for buttons and vsync ----------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            vs_p0  <= 1'b0;
            vs_p1  <= 1'b0;
            vs_p2  <= 1'b0;
        end else begin
            btn_p0 <= btn_raw;
            btn_p1 <= btn_p0;
            vs_p0  <= vsync;
            vs_p1  <= vs_p0;
            vs_p2  <= vs_p1;
        end
    end

    // vs_p2 is the previous synced sample, so this fires once per falling edge.
    assign frame_tick = vs_p2 & ~vs_p1;

    // ---- stage db: per-button debouncer on the synced value ------------------
    // The counter only runs while the synced and accepted values disagree; any
    // agreement, even for one cycle, restarts the qualification window.
    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [19:0] cnt;
        logic        db_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt  <= '0;
                db_q <= 1'b0;
            end else if (btn_p1[i] != db_q) begin
                if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
                    db_q <= btn_p1[i];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign btn_db[i] = db_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_prev <= 1'b0;
        end else begin
            c_prev <= btn_db[BTN_C];
        end
    end

    assign c_press = btn_db[BTN_C] & ~c_prev;

    // ---- stage fsm: game sequencing with registered outputs ------------------
    // fcnt counts frame ticks by default; every transition and every move wrap
    // overrides that with a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fcnt      <= '0;
            dir       <= 2'b11;
            move_en   <= 1'b0;
            level_rst <= 1'b0;
            lives     <= LIVES_INIT;
        end else begin
            move_en   <= 1'b0;
            level_rst <= 1'b0;
            if (frame_tick) begin
                fcnt <= fcnt + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (c_press) begin
                        state_q   <= S_READY;
                        fcnt      <= '0;
                        lives     <= LIVES_INIT;
                        level_rst <= 1'b1;
                        dir       <= 2'b11;
                    end
                end

                S_READY: begin
                    if (frame_tick && fcnt == READY_FRAMES - 8'd1) begin
                        state_q <= S_PLAY;
                        fcnt    <= '0;
                    end
                end

                S_PLAY: begin
                    // Direction priority: up > down > left > right.
                    if (btn_db[BTN_U]) begin
                        dir <= 2'b00;
                    end else if (btn_db[BTN_D]) begin
                        dir <= 2'b01;
                    end else if (btn_db[BTN_L]) begin
                        dir <= 2'b10;
                    end else if (btn_db[BTN_R]) begin
                        dir <= 2'b11;
                    end

                    // A death outranks both a pause request and a move step.
                    if (pacman_dead) begin
                        state_q <= S_DYING;
                        fcnt    <= '0;
                        lives   <= lives - 2'd1;
                    end else if (c_press) begin
                        state_q <= S_PAUSE;
                        fcnt    <= '0;
                    end else if (frame_tick && fcnt == MOVE_DIV - 8'd1) begin
                        move_en <= 1'b1;
                        fcnt    <= '0;
                    end
                end

                S_PAUSE: begin
                    if (c_press) begin
                        state_q <= S_PLAY;
                        fcnt    <= '0;
                    end
                end

                S_DYING: begin
                    if (frame_tick && fcnt == DEATH_FRAMES - 8'd1) begin
                        fcnt <= '0;
                        if (lives != 2'd0) begin
                            state_q   <= S_READY;
                            level_rst <= 1'b1;
                            dir       <= 2'b11;
                        end else begin
                            state_q <= S_OVER;
                        end
                    end
                end

                S_OVER: begin
                    if (c_press) begin
                        state_q <= S_IDLE;
                        fcnt    <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    fcnt    <= '0;
                end
            endcase
        end
    end

    assign game_state = state_q;
    assign freeze     = (state_q != S_PLAY);

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Testbench for game_ctrl_fsm: table-driven scenario phases with hand-derived
// expectations, hand-written corner sequences, and a randomized run compared
// every cycle against a behavioural model of the game rules.
module tb_game_ctrl_fsm;

    localparam logic [19:0] DEB      = 20'd4;
    localparam logic [7:0]  MDIV     = 8'd2;
    localparam logic [7:0]  RFRAMES  = 8'd2;
    localparam logic [7:0]  DFRAMES  = 8'd3;
    localparam logic [1:0]  LIVES0   = 2'd2;

    localparam logic [4:0] BU = 5'b00001;
    localparam logic [4:0] BD = 5'b00010;
    localparam logic [4:0] BL = 5'b00100;
    localparam logic [4:0] BC = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;
    logic       vsync = 1'b1;
    logic       pacman_dead = 1'b0;
    logic [2:0] game_state;
    logic [1:0] dir;
    logic       move_en;
    logic       level_rst;
    logic       freeze;
    logic [1:0] lives;

    always #5 clk = ~clk;

    game_ctrl_fsm #(
        .DEBOUNCE_CYCLES(DEB),
        .MOVE_DIV(MDIV),
        .READY_FRAMES(RFRAMES),
        .DEATH_FRAMES(DFRAMES),
        .LIVES_INIT(LIVES0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_u(btn[0]),
        .btn_d(btn[1]),
        .btn_l(btn[2]),
        .btn_r(btn[3]),
        .btn_c(btn[4]),
        .vsync(vsync),
        .pacman_dead(pacman_dead),
        .game_state(game_state),
        .dir(dir),
        .move_en(move_en),
        .level_rst(level_rst),
        .freeze(freeze),
        .lives(lives)
    );

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int lr_seen = 0;
    int mv_seen = 0;

    // ---------------- behavioural reference model ----------------
    // States as plain numbers 0..5; mf = frame ticks seen since the state
    // was entered (or since the last move step in play).
    int         ms, mdir, mlives, mf;
    logic       mmove, mlvl;
    logic       db_m [5];
    int         run_m [5];
    logic       cprev_m;
    logic [5:0] hist[$];   // raw {vsync, buttons} samples, newest first

    task automatic model_reset();
        ms = 0; mdir = 3; mlives = int'(LIVES0); mf = 0;
        mmove = 1'b0; mlvl = 1'b0; cprev_m = 1'b0;
        for (int i = 0; i < 5; i++) begin
            db_m[i] = 1'b0;
            run_m[i] = 0;
        end
        hist = {6'd0, 6'd0, 6'd0};
    endtask

    // Frame tick visible in the current cycle: vsync was high three samples
    // back and low two samples back.
    function automatic logic tick_now();
        return hist[2][5] && !hist[1][5];
    endfunction

    task automatic enter_ready();
        ms = 1; mf = 0; mlvl = 1'b1; mdir = 3;
    endtask

    task automatic model_step(input logic [4:0] b, input logic v, input logic dead);
        logic cp;
        logic tk;
        logic s;
        cp = db_m[4] && !cprev_m;
        tk = tick_now();
        mmove = 1'b0;
        mlvl = 1'b0;
        if (ms == 2) begin
            if (db_m[0]) mdir = 0;
            else if (db_m[1]) mdir = 1;
            else if (db_m[2]) mdir = 2;
            else if (db_m[3]) mdir = 3;
        end
        case (ms)
            0: if (cp) begin enter_ready(); mlives = int'(LIVES0); end
            1: if (tk) begin
                   mf++;
                   if (mf == int'(RFRAMES)) begin ms = 2; mf = 0; end
               end
            2: if (dead) begin ms = 4; mf = 0; mlives--; end
               else if (cp) begin ms = 3; mf = 0; end
               else if (tk) begin
                   mf++;
                   if (mf == int'(MDIV)) begin mmove = 1'b1; mf = 0; end
               end
            3: if (cp) begin ms = 2; mf = 0; end
            4: if (tk) begin
                   mf++;
                   if (mf == int'(DFRAMES)) begin
                       if (mlives != 0) enter_ready();
                       else begin ms = 5; mf = 0; end
                   end
               end
            default: if (cp) begin ms = 0; mf = 0; end
        endcase
        // A button value is accepted once its synced copy has disagreed with
        // the accepted value for DEB consecutive samples.
        cprev_m = db_m[4];
        for (int i = 0; i < 5; i++) begin
            s = hist[1][i];
            if (s != db_m[i]) begin
                run_m[i]++;
                if (run_m[i] == int'(DEB)) begin
                    db_m[i] = s;
                    run_m[i] = 0;
                end
            end else begin
                run_m[i] = 0;
            end
        end
        hist.push_front({v, b});
        void'(hist.pop_back());
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        logic [9:0] e;
        e = {3'(ms), 2'(mdir), mmove, mlvl, (ms != 2), 2'(mlives)};
        chk("model{state,dir,move,lvl,frz,lives}",
            {22'd0, game_state, dir, move_en, level_rst, freeze, lives}, {22'd0, e});
    endtask

    // Called just after a falling edge: drive inputs, advance one clock,
    // then compare outputs on the next falling edge.
    task automatic cyc();
        vsync = (vcnt != 49);
        vcnt = (vcnt + 1) % 50;
        @(posedge clk);
        if (!rst) model_step(btn, vsync, pacman_dead);
        @(negedge clk);
        chk_model();
        lr_seen += int'(level_rst);
        mv_seen += int'(move_en);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        logic [4:0] b;
        logic       dead;
        int         cycles;
        int         st;
        int         lv;
        int         dr;
        int         lr;
        int         mv;   // -1: do not check move count
    } vec_t;

    vec_t tab[15];

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            btn = tab[i].b;
            pacman_dead = tab[i].dead;
            lr_seen = 0;
            mv_seen = 0;
            repeat (tab[i].cycles) cyc();
            chk($sformatf("row%0d_state", i), game_state, tab[i].st);
            chk($sformatf("row%0d_lives", i), lives, tab[i].lv);
            chk($sformatf("row%0d_dir", i), dir, tab[i].dr);
            chk($sformatf("row%0d_level_rst_count", i), lr_seen, tab[i].lr);
            if (tab[i].mv >= 0) chk($sformatf("row%0d_move_count", i), mv_seen, tab[i].mv);
        end
        btn = '0;
        pacman_dead = 1'b0;
    endtask

    initial begin
        int found;

        tab[0]  = '{5'd0, 1'b0,  20, 0, 2, 3, 0,  0};
        tab[1]  = '{BC,   1'b0,  10, 1, 2, 3, 1,  0};
        tab[2]  = '{5'd0, 1'b0, 120, 2, 2, 3, 0, -1};
        tab[3]  = '{5'd0, 1'b0, 170, 1, 1, 3, 1,  0};
        tab[4]  = '{5'd0, 1'b0, 100, 2, 1, 3, 0, -1};
        tab[5]  = '{5'd0, 1'b1,   1, 4, 0, 3, 0,  0};
        tab[6]  = '{5'd0, 1'b0, 170, 5, 0, 3, 0,  0};
        tab[7]  = '{BC,   1'b1,  10, 0, 0, 3, 0,  0};
        tab[8]  = '{5'd0, 1'b1,  60, 0, 0, 3, 0,  0};
        tab[9]  = '{BC,   1'b0,  10, 1, 2, 3, 1,  0};
        tab[10] = '{5'd0, 1'b0, 120, 2, 2, 3, 0, -1};
        tab[11] = '{BC,   1'b0,  10, 3, 2, 3, 0, -1};
        tab[12] = '{BD,   1'b0,  20, 3, 2, 3, 0,  0};
        tab[13] = '{BC,   1'b0,  10, 2, 2, 3, 0,  0};
        tab[14] = '{5'd0, 1'b0,  20, 2, 2, 3, 0, -1};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", game_state, 0);
        chk("reset_dir", dir, 3);
        chk("reset_move_en", move_en, 0);
        chk("reset_level_rst", level_rst, 0);
        chk("reset_freeze", freeze, 1);
        chk("reset_lives", lives, 2);
        rst = 1'b0;

        // Start the game and reach PLAY.
        run_rows(0, 2);

        // Bouncing up-button shorter than the debounce window.
        for (int k = 0; k < 5; k++) begin
            btn = BU; cyc(); cyc();
            btn = '0; cyc(); cyc();
        end
        chk("bounce_dir", dir, 3);
        repeat (4) cyc();

        // Four frame ticks in 200 cycles give exactly two move steps.
        mv_seen = 0;
        repeat (200) cyc();
        chk("move_count_200", mv_seen, 2);
        chk("move_state", game_state, 2);

        // Up and left together: up wins, visible one edge after debounce.
        btn = BU | BL;
        repeat (6) cyc();
        chk("dir_before_debounce", dir, 3);
        cyc();
        chk("dir_after_debounce", dir, 0);
        btn = '0;
        repeat (10) cyc();
        chk("dir_hold_release", dir, 0);

        // Death on the tick that would have produced a move step.
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            if (ms == 2 && tick_now() && mf == int'(MDIV) - 1) found = 1;
            else cyc();
        end
        chk("dead_move_tick_found", found, 1);
        pacman_dead = 1'b1;
        cyc();
        pacman_dead = 1'b0;
        chk("dead_suppress_move", move_en, 0);
        chk("dead_state", game_state, 4);
        chk("dead_lives", lives, 1);

        // Recovery, game over, restart, pause.
        run_rows(3, 14);
        chk("play_freeze", freeze, 0);

        // Centre press and death in the same cycle: death wins.
        btn = BC;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (db_m[4] && !cprev_m) found = 1;
            else cyc();
        end
        chk("c_press_found", found, 1);
        pacman_dead = 1'b1;
        cyc();
        pacman_dead = 1'b0;
        btn = '0;
        chk("dead_vs_pause_state", game_state, 4);
        chk("dead_vs_pause_lives", lives, 1);

        // Asynchronous reset in the middle of DYING.
        repeat (5) cyc();
        chk("pre_reset_state", game_state, 4);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_state", game_state, 0);
        chk("async_rst_dir", dir, 3);
        chk("async_rst_move_en", move_en, 0);
        chk("async_rst_level_rst", level_rst, 0);
        chk("async_rst_freeze", freeze, 1);
        chk("async_rst_lives", lives, 2);
        repeat (3) cyc();
        #2 rst = 1'b0;
        repeat (30) cyc();
        chk("post_reset_idle", game_state, 0);
        btn = BC;
        repeat (10) cyc();
        btn = '0;
        chk("post_reset_start", game_state, 1);

        // Randomized play against the model.
        repeat (5000) begin
            if ($urandom_range(0, 5) == 0) btn = 5'($urandom) & 5'($urandom);
            pacman_dead = ($urandom_range(0, 30) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog t=%0t got timeout expected finish", $time);
        $fatal(1);
    end

endmodule
